// File: rtl/lfsr_stream_checker_if.sv
// LFSR seed / random-number handshake between lfsr_stream_checker (master) and the LFSR (slave).
interface lfsr_stream_checker_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] seed_in;
  logic                  seed_valid;
  logic [DATA_WIDTH-1:0] random_number;
  logic                  random_number_valid;

  modport master (
    output seed_in,
    output seed_valid,
    input  random_number,
    input  random_number_valid
  );

  modport slave (
    input  seed_in,
    input  seed_valid,
    output random_number,
    output random_number_valid
  );
endinterface

// File: rtl/lfsr_stream_checker.sv
// Seeds an LFSR, captures DEPTH words into a buffer and, with LFSR_STREAM_CHECK_EN defined,
// checks each word against the Fibonacci next-state function (capture-only otherwise).
module lfsr_stream_checker #(
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] TAPS       = 16'hB400,
  parameter int                    DEPTH      = 10,
  parameter logic [DATA_WIDTH-1:0] SEED       = 16'hFFFF,
  parameter int                    AW         = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  lfsr_stream_checker_if.master lfsr,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  done,
  output logic                  mismatch,
  output logic [7:0]            error_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEED    = 2'd1,
    ST_COLLECT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [AW-1:0]         LAST_C  = AW'(DEPTH - 1);
  localparam logic [AW-1:0]         ONE_C   = AW'(1);
  localparam logic [AW:0]           DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] ZERO_W  = {DATA_WIDTH{1'b0}};

  state_t                state_r, state_next_s;
  logic [AW-1:0]         cnt_r;
  logic                  done_r;
  logic                  seed_valid_r;
  logic [DATA_WIDTH-1:0] seed_in_r;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic [DATA_WIDTH-1:0] buf_r [0:(1<<AW)-1];
  logic                  accept_s;
  logic                  seed_entry_s;
  logic                  rd_in_range_s;

  assign accept_s      = (state_r == ST_COLLECT) && lfsr.random_number_valid;
  assign seed_entry_s  = (state_next_s == ST_SEED);
  assign rd_in_range_s = ({1'b0, rd_addr} < DEPTH_C);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_SEED;
        else       state_next_s = ST_IDLE;
      end
      ST_SEED: state_next_s = ST_COLLECT;
      ST_COLLECT: begin
        if (accept_s && (cnt_r == LAST_C)) state_next_s = ST_DONE;
        else                               state_next_s = ST_COLLECT;
      end
      ST_DONE: begin
        if (start) state_next_s = ST_SEED;
        else       state_next_s = ST_DONE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Seed strobe, capture counter, done level and registered read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seed_valid_r <= 1'b0;
      seed_in_r    <= ZERO_W;
      cnt_r        <= {AW{1'b0}};
      done_r       <= 1'b0;
      rd_data_r    <= ZERO_W;
    end else begin
      seed_valid_r <= seed_entry_s;
      seed_in_r    <= seed_entry_s ? SEED : ZERO_W;
      rd_data_r    <= rd_in_range_s ? buf_r[rd_addr] : ZERO_W;
      if (seed_entry_s) begin
        cnt_r  <= {AW{1'b0}};
        done_r <= 1'b0;
      end else if (accept_s) begin
        cnt_r <= cnt_r + ONE_C;
        if (cnt_r == LAST_C) done_r <= 1'b1;
      end
    end
  end

  // Capture buffer; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (accept_s) buf_r[cnt_r] <= lfsr.random_number;
  end

  assign lfsr.seed_valid = seed_valid_r;
  assign lfsr.seed_in    = seed_in_r;
  assign rd_data         = rd_data_r;
  assign done            = done_r;

`ifdef LFSR_STREAM_CHECK_EN
  logic [DATA_WIDTH-1:0] expected_r;
  logic                  sync_r;
  logic                  mismatch_r;
  logic [7:0]            error_count_r;
  logic                  fail_s;

  function automatic logic [DATA_WIDTH-1:0] step_f(input logic [DATA_WIDTH-1:0] x);
    return {x[DATA_WIDTH-2:0], ^(x & TAPS)};
  endfunction

  // A zero word is the LFSR lockup state and never a usable sync reference.
  always_comb begin
    fail_s = 1'b0;
    if (lfsr.random_number == ZERO_W) begin
      fail_s = 1'b1;
    end else if (sync_r && (lfsr.random_number != step_f(expected_r))) begin
      fail_s = 1'b1;
    end else begin
      fail_s = 1'b0;
    end
  end

  // Reference tracking, mismatch pulse and saturating failure count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      expected_r    <= ZERO_W;
      sync_r        <= 1'b0;
      mismatch_r    <= 1'b0;
      error_count_r <= 8'h00;
    end else begin
      mismatch_r <= accept_s & fail_s;
      if (seed_entry_s) begin
        sync_r        <= 1'b0;
        error_count_r <= 8'h00;
      end else if (accept_s) begin
        if (fail_s && (error_count_r != 8'hFF)) error_count_r <= error_count_r + 8'h01;
        if (sync_r || (lfsr.random_number != ZERO_W)) begin
          expected_r <= lfsr.random_number;
          sync_r     <= 1'b1;
        end
      end
    end
  end

  assign mismatch    = mismatch_r;
  assign error_count = error_count_r;
`else
  assign mismatch    = 1'b0;
  assign error_count = 8'h00;
`endif

endmodule

// File: doc/lfsr_stream_checker.md
# lfsr_stream_checker

Consumer-side companion to the `LFSR` generator. It drives the LFSR's seed handshake, then captures the resulting `random_number` stream into a small on-chip buffer. It also checks each word against the next-state function of the 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1). The block sits directly on the LFSR's `seed_in`/`seed_valid`/`random_number`/`random_number_valid` interface and replaces bench-side collection logic in hardware self-test.

## Interface
- `DATA_WIDTH`, 16, width of seed and random words
- `TAPS`, 16'hB400, feedback tap mask; bits 15, 13, 12, 10
- `DEPTH`, 10, number of words captured per run
- `SEED`, 16'hFFFF, seed value driven on `seed_in`
- `AW`, 4, buffer address width; must satisfy 2^AW >= DEPTH
- `clk` input 1: single clock, rising edge
- `rst` input 1: reset, asynchronous and active-high
- `start` input 1: one-cycle run request
- `seed_in` output DATA_WIDTH: seed to LFSR; constant `SEED` while `seed_valid`=1, otherwise 0
- `seed_valid` output 1: one-cycle seed strobe
- `random_number` input DATA_WIDTH: word from LFSR
- `random_number_valid` input 1: qualifies `random_number`
- `rd_addr` input AW: buffer read address
- `rd_data` output DATA_WIDTH: registered buffer read data
- `done` output 1: capture complete; level
- `mismatch` output 1: one-cycle pulse per failed check
- `error_count` output 8: saturating failed-check count

## Operation
- The FSM has four states: IDLE, SEED, COLLECT, DONE.
- IDLE:
  - `start`=1 goes to SEED.
  - Entering SEED clears `cnt`, `error_count`, `done` and the sync flag.
- SEED: lasts exactly one cycle with `seed_valid`=1 and `seed_in`=`SEED`, then goes to COLLECT.
- COLLECT: each cycle with `random_number_valid`=1:
  - writes `buf[cnt]` <= `random_number`;
  - increments `cnt`;
  - runs the check.
  - The write with `cnt`=DEPTH-1 goes to DONE.
- DONE: `done`=1. `start`=1 re-enters SEED, which restarts the run.
- `start` is ignored in SEED and COLLECT. `random_number_valid` is ignored outside COLLECT.
- The check is self-synchronizing:
  - The first captured word loads `expected` and sets the sync flag; it is not compared.
  - `step(x)` = {x[DATA_WIDTH-2:0], ^(x & TAPS)}.
  - Each later word is compared with `step(expected)`. Afterwards `expected` <= the received word, whether it matched or not.
  - A received word of 0 (LFSR lockup) always counts as a failure, including the first word.
- On failure, `error_count` increments, saturating at 255, and `mismatch` pulses.
- Buffer read: `rd_data` <= `buf[rd_addr]` on every clock. `rd_addr` >= DEPTH returns 0. Reads are legal in any state.

## Timing
- Reset values:
  - state IDLE;
  - `seed_valid`, `seed_in`, `done`, `mismatch`, `error_count`, `rd_data` all 0;
  - `cnt`=0, sync flag cleared.
  - Buffer contents are not reset.
- `start` sampled at edge N gives `seed_valid`=1 during cycle N+1. COLLECT begins at edge N+2.
- Capture timing: a word accepted at edge K is readable via `rd_data` at edge K+1 at the earliest (one-cycle read latency).
- `mismatch` is asserted in the cycle after the failing word's edge. `error_count` updates at the same edge.
- `done` rises at the edge that accepts word DEPTH-1. It holds until the next SEED entry or reset.
- Back-to-back valids (one per cycle) are fully supported; no backpressure exists.
- Reset mid-COLLECT: the block returns to IDLE immediately, and all outputs go to their reset values asynchronously.

## Configuration
- `LFSR_STREAM_CHECK_EN` defined: the check logic, `expected` register, `mismatch` and `error_count` are present as specified.
- Not defined: the block captures only. `mismatch` and `error_count` are tied to 0, and no `step` logic is synthesized.

## Test plan
- Reset then `start`:
  - `seed_valid`=1 for exactly one cycle with `seed_in`=16'hFFFF;
  - `done`=0 and `error_count`=0 afterwards.
- Feed FFFE, FFFC, FFF8, FFF0, FFE0, FFC0, FF80, FF00, FE00, FC00 on consecutive cycles:
  - `done`=1 after the 10th word;
  - `error_count`=0;
  - reading addresses 0..9 returns those words in order;
  - address 12 returns 0.
- Same stream with word 4 replaced by 1234:
  - `mismatch` pulses twice (words 4 and 5);
  - `error_count`=2.
- Include 0000 as the first word: `error_count`=1.
- Assert `rst` after 5 words:
  - all outputs are 0 and the state is IDLE;
  - a subsequent `start` with a clean stream reaches `done` with `error_count`=0.
- With the macro undefined, feed the corrupted stream: `mismatch` stays 0, `error_count` stays 0, and the buffer contents are still correct.
